ex_branch_ctrl: RTL
===================

EX_BRANCH_CTRL -- requirements
Module: ex_branch_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, meaning the number of cycles `valid` is held low after a taken branch; legal range 1..3.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ex_live  input  1  EX holds a real instruction, not a bubble.
REQ-005 SHALL have port branch  input  1  EX instruction is a branch.
REQ-006 SHALL have port cond_branch  input  1  the branch is taken only if T=1.
REQ-007 SHALL have port target  input  32  branch target address from EX.
REQ-008 SHALL have port t_set  input  1  EX instruction writes the T flag.
REQ-009 SHALL have port t_result  input  1  new T value, with invert_t already applied.
REQ-010 SHALL have port stall  input  1  downstream freeze.
REQ-011 SHALL have port redirect  output  1  IF loads redirect_addr at the next edge.
REQ-012 SHALL have port redirect_addr  output  32  fetch redirect address.
REQ-013 SHALL have port valid  output  1  0 = ID/EX and IF/ID load bubbles at the next edge.
REQ-014 SHALL have port ex_kill  output  1  suppress the side effects of the current EX instruction.
REQ-015 SHALL have port t_flag  output  1  architectural T flag.
REQ-016 SHALL have port taken_count  output  32  count of taken branches.

Function
REQ-017 SHALL compute taken = ex_live & !ex_kill & branch & (!cond_branch | t_flag), using T as it was before this instruction's own T update.
REQ-018 SHALL update T at the edge when ex_live & !ex_kill & t_set & !stall, so the next instruction sees the new value (no bubble).
REQ-019 SHALL implement an FSM with states BR_RUN and BR_FLUSH, plus a 2-bit flush counter.
REQ-020 SHALL, in BR_RUN, with taken=1 and stall=0, at the edge:
- go to BR_FLUSH;
- load the counter with FLUSH_CYCLES;
- register redirect=1 and redirect_addr=target.
REQ-021 SHALL hold redirect high for exactly one cycle (the first BR_FLUSH cycle), clearing it at the following edge unless stall=1.
REQ-022 SHALL drive valid = (state==BR_RUN) and ex_kill = (state==BR_FLUSH), both as registered decodes with no combinational input-to-output path.
REQ-023 SHALL, in BR_FLUSH, decrement the counter each non-stalled edge, and return to BR_RUN when it reaches 0; BR_FLUSH therefore lasts FLUSH_CYCLES non-stalled cycles.
REQ-024 SHALL NOT evaluate branches or update T during BR_FLUSH, since those instructions are wrong-path.
REQ-025 SHALL, while stall=1, freeze state, counter, T, redirect, redirect_addr and taken_count, with all outputs held.
REQ-026 SHALL ignore a taken branch presented while stall=1; it is re-evaluated on the first non-stalled cycle.
REQ-027 SHALL increment taken_count by 1 per accepted taken branch (REQ-020), wrapping 0xFFFFFFFF to 0x00000000.
REQ-028 SHALL treat a branch with ex_live=0 as a no-op, regardless of branch or cond_branch.

Reset
REQ-029 SHALL, on rst_n low (immediately, without waiting for clk), enter state BR_RUN with counter=0.
REQ-030 SHALL, during reset, drive redirect=0, redirect_addr=0, valid=1, ex_kill=0, t_flag=0 and taken_count=0.
REQ-031 SHALL abort any flush in progress when reset asserts; the first post-reset cycle is BR_RUN with no redirect.

Structure
REQ-032 SHALL place branch_state_t (BR_RUN, BR_FLUSH) and the constant BR_FLUSH_MAX=3 in the shared types package.
REQ-033 SHALL be a single module with no sub-modules; the counter and FSM are local.

Verification
REQ-034 SHALL cover an unconditional taken branch: ex_live=1, branch=1, target=0x100 (FLUSH_CYCLES=1) -> next cycle redirect=1, redirect_addr=0x100, valid=0, ex_kill=1; the cycle after, valid=1, redirect=0, taken_count=1.
REQ-035 SHALL cover T forwarding: setter t_set=1, t_result=1, then cond_branch=1 on the next cycle -> taken; repeat with t_result=0 -> not taken, valid stays 1.
REQ-036 SHALL cover stall during flush: stall=1 for 3 cycles in the first BR_FLUSH cycle -> redirect, ex_kill and valid=0 held 3 extra cycles, and redirect_addr unchanged.
REQ-037 SHALL cover wrong-path suppression: branch plus t_set on the instruction in BR_FLUSH -> no second redirect, t_flag unchanged, taken_count +1 only.
REQ-038 SHALL cover wrap-around: taken_count forced to 0xFFFFFFFF, then one taken branch -> 0x00000000.
REQ-039 SHALL cover reset mid-flush: rst_n low between clock edges with FLUSH_CYCLES=3 -> outputs take reset values immediately; the post-reset cycle has valid=1 and redirect=0.

Source files
------------

// File: rtl/ex_branch_ctrl_pkg.sv
// Shared types for the EX-stage branch controller.
//   branch_state_t : BR_RUN (normal issue) / BR_FLUSH (wrong-path squash window)
//   BR_FLUSH_MAX   : largest flush length the 2-bit flush counter can hold
package ex_branch_ctrl_pkg;

  typedef enum logic {
    BR_RUN   = 1'b0,
    BR_FLUSH = 1'b1
  } branch_state_t;

  localparam int BR_FLUSH_MAX = 3;

endpackage

// File: rtl/ex_branch_ctrl.sv
// EX-stage branch resolution and fetch redirect control.
//
// Resolves branches in EX against the architectural T flag, redirects fetch
// on a taken branch and squashes the wrong-path instructions behind it for
// FLUSH_CYCLES non-stalled cycles.
//
// Handshake: there is no valid/ready pair here. 'stall' is a global freeze:
// while it is high every register holds and all outputs stay constant, and
// any branch presented in EX is not accepted until the first cycle with
// stall low. 'valid' low tells ID/EX and IF/ID to load bubbles at the next
// edge; 'redirect' high tells IF to load redirect_addr at the next edge.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   ex_live        EX holds a real instruction (not a bubble)
//   branch         EX instruction is a branch
//   cond_branch    branch is taken only when T=1
//   target[31:0]   branch target
//   t_set          EX instruction writes T
//   t_result       new T value (inversion already applied)
//   stall          downstream freeze
//   redirect       IF loads redirect_addr at the next edge
//   redirect_addr  fetch redirect address
//   valid          0 = pipeline registers load bubbles
//   ex_kill        suppress side effects of the EX instruction
//   t_flag         architectural T flag
//   taken_count    number of accepted taken branches (wraps)
module ex_branch_ctrl
  import ex_branch_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_live,
  input  logic        branch,
  input  logic        cond_branch,
  input  logic [31:0] target,
  input  logic        t_set,
  input  logic        t_result,
  input  logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_addr,
  output logic        valid,
  output logic        ex_kill,
  output logic        t_flag,
  output logic [31:0] taken_count
);

  // Out-of-range parameter values are clamped into 1..BR_FLUSH_MAX.
  localparam int FLUSH_CLAMP = (FLUSH_CYCLES < 1) ? 1 :
                               (FLUSH_CYCLES > BR_FLUSH_MAX) ? BR_FLUSH_MAX : FLUSH_CYCLES;
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CLAMP);

  branch_state_t state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          t_q, t_d;
  logic          redirect_q, redirect_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   count_q, count_d;
  logic          kill;
  logic          taken;

  // Both are pure decodes of the state register, so no input reaches them
  // combinationally.
  assign valid   = (state_q == BR_RUN);
  assign ex_kill = (state_q == BR_FLUSH);
  assign kill    = ex_kill;

  // T is sampled before this instruction's own T update takes effect.
  assign taken = ex_live & ~kill & branch & (~cond_branch | t_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    t_d        = t_q;
    redirect_d = redirect_q;
    addr_d     = addr_q;
    count_d    = count_q;

    if (!stall) begin
      // kill is high throughout BR_FLUSH, so wrong-path setters never land.
      if (ex_live && !kill && t_set) begin
        t_d = t_result;
      end

      unique case (state_q)
        BR_RUN: begin
          redirect_d = 1'b0;
          if (taken) begin
            state_d    = BR_FLUSH;
            cnt_d      = FLUSH_LOAD;
            redirect_d = 1'b1;
            addr_d     = target;
            count_d    = count_q + 32'd1;
          end
        end
        BR_FLUSH: begin
          // redirect is only meaningful in the first flush cycle.
          redirect_d = 1'b0;
          cnt_d      = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
          if (cnt_q <= 2'd1) begin
            state_d = BR_RUN;
          end
        end
        default: begin
          state_d = BR_RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // FSM state and flush counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BR_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Architectural / output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q        <= 1'b0;
      redirect_q <= 1'b0;
      addr_q     <= 32'd0;
      count_q    <= 32'd0;
    end else begin
      t_q        <= t_d;
      redirect_q <= redirect_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
    end
  end

  assign redirect      = redirect_q;
  assign redirect_addr = addr_q;
  assign t_flag        = t_q;
  assign taken_count   = count_q;

endmodule
